// File: rtl/nic_fifo.sv
// Network interface between a memory-mapped processor port and one mesh router port.
// Each direction has a FIFO with occupancy counts and sticky overflow/underflow status.
module nic_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int OUT_DEPTH  = 4,
    parameter int IN_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [DATA_WIDTH-1:0] net_do,
    output logic                  net_so,
    input  logic                  net_ro,
    input  logic                  net_polarity,
    input  logic [DATA_WIDTH-1:0] net_di,
    input  logic                  net_si,
    output logic                  net_ri
);

    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam int OPW = $clog2(OUT_DEPTH);
    localparam int ICW = $clog2(IN_DEPTH + 1);
    localparam int IPW = $clog2(IN_DEPTH);
    localparam logic [OCW-1:0] OUT_FULL_CNT = OCW'(OUT_DEPTH);
    localparam logic [ICW-1:0] IN_FULL_CNT  = ICW'(IN_DEPTH);

    logic [DATA_WIDTH-1:0] r_out_mem [OUT_DEPTH];
    logic [DATA_WIDTH-1:0] r_in_mem  [IN_DEPTH];
    logic [OPW-1:0]        r_out_wptr, r_out_rptr;
    logic [IPW-1:0]        r_in_wptr, r_in_rptr;
    logic [OCW-1:0]        r_out_count;
    logic [ICW-1:0]        r_in_count;
    logic                  r_out_ovf, r_in_ovf, r_in_unf;

    logic                  w_wr, w_rd;
    logic                  w_out_empty, w_out_full, w_in_empty, w_in_full;
    logic                  w_out_push, w_out_ovf_set, w_net_so;
    logic                  w_in_push, w_in_pop, w_in_ovf_set, w_in_unf_set;
    logic                  w_flag_clr;
    logic [DATA_WIDTH-1:0] w_net_do, w_in_head;
    logic [DATA_WIDTH-1:0] w_in_status, w_out_status;

    assign w_wr        = nicEn & nicWrEn;
    assign w_rd        = nicEn & ~nicWrEn;
    assign w_out_empty = (r_out_count == {OCW{1'b0}});
    assign w_out_full  = (r_out_count == OUT_FULL_CNT);
    assign w_in_empty  = (r_in_count == {ICW{1'b0}});
    assign w_in_full   = (r_in_count == IN_FULL_CNT);

    // A full output FIFO can still take a write in the cycle its head leaves.
    assign w_net_do      = w_out_empty ? {DATA_WIDTH{1'b0}} : r_out_mem[r_out_rptr];
    assign w_net_so      = ~w_out_empty & net_ro & (w_net_do[DATA_WIDTH-1] != net_polarity);
    assign w_out_push    = w_wr & (addr == 2'b10) & (~w_out_full | w_net_so);
    assign w_out_ovf_set = w_wr & (addr == 2'b10) & w_out_full & ~w_net_so;

    assign w_in_head     = w_in_empty ? {DATA_WIDTH{1'b0}} : r_in_mem[r_in_rptr];
    assign w_in_push     = net_si & ~w_in_full;
    assign w_in_ovf_set  = net_si & w_in_full;
    assign w_in_pop      = w_rd & (addr == 2'b00) & ~w_in_empty;
    assign w_in_unf_set  = w_rd & (addr == 2'b00) & w_in_empty;
    assign w_flag_clr    = w_wr & (addr == 2'b11) & d_in[16];

    assign net_do = w_net_do;
    assign net_so = w_net_so;
    assign net_ri = ~w_in_full;

    // Status words: counts zero-extended into bits [15:8], sticky flags above.
    always_comb begin
        w_in_status      = {DATA_WIDTH{1'b0}};
        w_out_status     = {DATA_WIDTH{1'b0}};
        w_in_status[0]   = ~w_in_empty;
        w_in_status[15:8] = 8'(r_in_count);
        w_in_status[16]  = r_in_unf;
        w_in_status[17]  = r_in_ovf;
        w_out_status[0]  = w_out_full;
        w_out_status[15:8] = 8'(r_out_count);
        w_out_status[16] = r_out_ovf;
    end

    // Processor read mux.
    always_comb begin
        d_out = {DATA_WIDTH{1'b0}};
        case (addr)
            2'b00:   d_out = w_in_head;
            2'b01:   d_out = w_in_status;
            2'b10:   d_out = {DATA_WIDTH{1'b0}};
            2'b11:   d_out = w_out_status;
            default: d_out = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Storage arrays; unread slots need no reset because empty heads are masked.
    always_ff @(posedge clk) begin
        if (w_out_push) r_out_mem[r_out_wptr] <= d_in;
        if (w_in_push)  r_in_mem[r_in_wptr]   <= net_di;
    end

    // Output FIFO pointers and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_wptr  <= {OPW{1'b0}};
            r_out_rptr  <= {OPW{1'b0}};
            r_out_count <= {OCW{1'b0}};
        end else begin
            if (w_out_push) r_out_wptr <= r_out_wptr + 1'b1;
            if (w_net_so)   r_out_rptr <= r_out_rptr + 1'b1;
            case ({w_out_push, w_net_so})
                2'b10:   r_out_count <= r_out_count + 1'b1;
                2'b01:   r_out_count <= r_out_count - 1'b1;
                default: r_out_count <= r_out_count;
            endcase
        end
    end

    // Input FIFO pointers and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_wptr  <= {IPW{1'b0}};
            r_in_rptr  <= {IPW{1'b0}};
            r_in_count <= {ICW{1'b0}};
        end else begin
            if (w_in_push) r_in_wptr <= r_in_wptr + 1'b1;
            if (w_in_pop)  r_in_rptr <= r_in_rptr + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_count <= r_in_count + 1'b1;
                2'b01:   r_in_count <= r_in_count - 1'b1;
                default: r_in_count <= r_in_count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_ovf <= 1'b0;
            r_in_ovf  <= 1'b0;
            r_in_unf  <= 1'b0;
        end else begin
            r_out_ovf <= w_out_ovf_set | (r_out_ovf & ~w_flag_clr);
            r_in_ovf  <= w_in_ovf_set  | (r_in_ovf  & ~w_flag_clr);
            r_in_unf  <= w_in_unf_set  | (r_in_unf  & ~w_flag_clr);
        end
    end

endmodule

// File: tb/tb_nic_fifo.sv
// Directed, table-driven bench for nic_fifo with DATA_WIDTH=64 and both depths 4.
module tb_nic_fifo;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic        nicEn, nicWrEn;
    logic [63:0] d_out, net_do;
    logic        net_so, net_ro, net_polarity;
    logic [63:0] net_di;
    logic        net_si, net_ri;

    int n_cmp = 0;
    int n_bad = 0;

    nic_fifo #(.DATA_WIDTH(64), .OUT_DEPTH(4), .IN_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .d_out(d_out),
        .net_do(net_do), .net_so(net_so), .net_ro(net_ro),
        .net_polarity(net_polarity), .net_di(net_di), .net_si(net_si),
        .net_ri(net_ri)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        en;
        logic        we;
        logic [63:0] din;
        logic        ro;
        logic        pol;
        logic        si;
        logic [63:0] di;
        logic [63:0] e_dout;
        logic [63:0] e_do;
        logic        e_so;
        logic        e_ri;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic [1:0] a, input logic en, input logic we,
                              input logic [63:0] din, input logic ro, input logic pol,
                              input logic si, input logic [63:0] di,
                              input logic [63:0] e_dout, input logic [63:0] e_do,
                              input logic e_so, input logic e_ri);
        vec_t r;
        r.addr = a; r.en = en; r.we = we; r.din = din; r.ro = ro; r.pol = pol;
        r.si = si; r.di = di; r.e_dout = e_dout; r.e_do = e_do; r.e_so = e_so; r.e_ri = e_ri;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] e_dout, input logic [63:0] e_do,
                           input logic e_so, input logic e_ri);
        chk({tag, " d_out"}, d_out, e_dout);
        chk({tag, " net_do"}, net_do, e_do);
        chk({tag, " net_so"}, {63'd0, net_so}, {63'd0, e_so});
        chk({tag, " net_ri"}, {63'd0, net_ri}, {63'd0, e_ri});
    endtask

    task automatic idle();
        addr = 2'b00; d_in = 64'd0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = 64'd0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        addr = 2'b01;
        #1;
        chk_all("in_reset", 64'd0, 64'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // addr en we din ro pol si di | d_out net_do so ri
        v(2'b01,0,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        v(2'b10,0,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        v(2'b11,0,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        v(2'b00,1,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,0,64'h0, 64'h10000, 64'h0,0,1);
        v(2'b11,1,1,64'h10000,0,0,0,64'h0, 64'h0, 64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        // output fill with router not ready, overflow on fifth write
        v(2'b10,1,1,64'h1,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        v(2'b10,1,1,64'h2,0,0,0,64'h0, 64'h0,     64'h1,0,1);
        v(2'b10,1,1,64'h3,0,0,0,64'h0, 64'h0,     64'h1,0,1);
        v(2'b10,1,1,64'h4,0,0,0,64'h0, 64'h0,     64'h1,0,1);
        v(2'b11,0,0,64'h0,0,0,0,64'h0, 64'h401,   64'h1,0,1);
        v(2'b10,1,1,64'h5,0,0,0,64'h0, 64'h0,     64'h1,0,1);
        v(2'b11,0,0,64'h0,0,0,0,64'h0, 64'h10401, 64'h1,0,1);
        // drain: four consecutive sends
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h10401, 64'h1,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h10300, 64'h2,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h10200, 64'h3,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h10100, 64'h4,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h10000, 64'h0,0,1);
        v(2'b11,1,1,64'h10000,0,0,0,64'h0, 64'h10000, 64'h0,0,1);
        v(2'b11,0,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        // push while full in the same cycle as a send
        v(2'b10,1,1,64'h1,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        v(2'b10,1,1,64'h2,0,0,0,64'h0, 64'h0,     64'h1,0,1);
        v(2'b10,1,1,64'h3,0,0,0,64'h0, 64'h0,     64'h1,0,1);
        v(2'b10,1,1,64'h4,0,0,0,64'h0, 64'h0,     64'h1,0,1);
        v(2'b10,1,1,64'h9,1,1,0,64'h0, 64'h0,     64'h1,1,1);
        v(2'b11,0,0,64'h0,0,0,0,64'h0, 64'h401,   64'h2,0,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h401,   64'h2,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h300,   64'h3,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h200,   64'h4,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h100,   64'h9,1,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h0,     64'h0,0,1);
        // polarity hold, then flip
        v(2'b10,1,1,64'h80000000000000AA,0,0,0,64'h0, 64'h0, 64'h0,0,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h100, 64'h80000000000000AA,0,1);
        v(2'b11,0,0,64'h0,1,1,0,64'h0, 64'h100, 64'h80000000000000AA,0,1);
        v(2'b11,0,0,64'h0,1,0,0,64'h0, 64'h100, 64'h80000000000000AA,1,1);
        v(2'b11,0,0,64'h0,1,0,0,64'h0, 64'h0,   64'h0,0,1);
        // input fill, overflow, drain, underflow
        v(2'b01,0,0,64'h0,0,0,1,64'hA, 64'h0,     64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,1,64'hB, 64'h101,   64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,1,64'hC, 64'h201,   64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,1,64'hD, 64'h301,   64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,1,64'hE, 64'h401,   64'h0,0,0);
        v(2'b01,0,0,64'h0,0,0,0,64'h0, 64'h20401, 64'h0,0,0);
        v(2'b00,1,0,64'h0,0,0,0,64'h0, 64'hA,     64'h0,0,0);
        v(2'b00,1,0,64'h0,0,0,0,64'h0, 64'hB,     64'h0,0,1);
        v(2'b00,1,0,64'h0,0,0,0,64'h0, 64'hC,     64'h0,0,1);
        v(2'b00,1,0,64'h0,0,0,0,64'h0, 64'hD,     64'h0,0,1);
        v(2'b00,1,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,0,64'h0, 64'h30000, 64'h0,0,1);
        v(2'b11,1,1,64'h10000,0,0,0,64'h0, 64'h0, 64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,0,64'h0, 64'h0,     64'h0,0,1);
        // simultaneous inbound push and processor pop
        v(2'b01,0,0,64'h0,0,0,1,64'h11, 64'h0,    64'h0,0,1);
        v(2'b00,1,0,64'h0,0,0,1,64'h22, 64'h11,   64'h0,0,1);
        v(2'b00,0,0,64'h0,0,0,0,64'h0,  64'h22,   64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,0,64'h0,  64'h101,  64'h0,0,1);
        v(2'b00,1,0,64'h0,0,0,0,64'h0,  64'h22,   64'h0,0,1);
        v(2'b01,0,0,64'h0,0,0,0,64'h0,  64'h0,    64'h0,0,1);

        foreach (tbl[i]) begin
            @(negedge clk);
            addr = tbl[i].addr; nicEn = tbl[i].en; nicWrEn = tbl[i].we; d_in = tbl[i].din;
            net_ro = tbl[i].ro; net_polarity = tbl[i].pol; net_si = tbl[i].si; net_di = tbl[i].di;
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].e_dout, tbl[i].e_do, tbl[i].e_so, tbl[i].e_ri);
        end

        // both FIFOs to count 2, then asynchronous reset between edges
        @(negedge clk);
        idle(); addr = 2'b10; nicEn = 1'b1; nicWrEn = 1'b1; d_in = 64'h1;
        net_si = 1'b1; net_di = 64'h55;
        @(negedge clk);
        d_in = 64'h2; net_di = 64'h66;
        @(negedge clk);
        idle(); addr = 2'b11;
        #1;
        chk("pre_reset out_status", d_out, 64'h200);
        addr = 2'b01;
        #1;
        chk("pre_reset in_status", d_out, 64'h201);
        reset = 1'b1;
        #1;
        chk_all("async_reset in_status", 64'h0, 64'h0, 1'b0, 1'b1);
        addr = 2'b11;
        #1;
        chk("async_reset out_status", d_out, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        addr = 2'b00;
        #1;
        chk("post_reset in_head", d_out, 64'h0);

        // sticky clear needs d_in[16]; other bits do nothing
        @(negedge clk);
        addr = 2'b00; nicEn = 1'b1; nicWrEn = 1'b0;
        @(negedge clk);
        addr = 2'b11; nicWrEn = 1'b1; d_in = 64'hFFFF_FFFF_FFFE_FFFF;
        @(negedge clk);
        idle(); addr = 2'b01;
        #1;
        chk("no_clear in_status", d_out, 64'h10000);
        @(negedge clk);
        addr = 2'b11; nicEn = 1'b1; nicWrEn = 1'b1; d_in = 64'h1_0000;
        @(negedge clk);
        idle(); addr = 2'b01;
        #1;
        chk("cleared in_status", d_out, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
